gate_sweep_controller: RTL
==========================

Name: gate_sweep_controller

Overview:
Sequencer that exhaustively exercises a 2-input combinational gate (XorGate by default) in hardware. On a start pulse it drives the four input vectors 00, 01, 10, 11 onto the gate, waits a programmable settle time, samples the gate output and checks it against a parameterised truth table. It accumulates a per-vector fail mask and an error count, then reports pass/fail. It sits between a control host or bring-up FSM and any BasicGates instance.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before its sample edge; legal range 1..255.
EXP_TABLE, 4'b0110, expected gate output indexed by vector {in0,in1}; bit i is the expected output for vector i; default is XOR.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin a sweep; sampled only in IDLE.
abort  input  1  cancel a sweep in progress; ignored when not busy.
gate_out  input  1  output of the gate under test.
gate_in0  output  1  drives gate in0; equals vector bit 1.
gate_in1  output  1  drives gate in1; equals vector bit 0.
busy  output  1  high while a sweep is running.
done  output  1  one-cycle pulse when a sweep completes normally.
aborted  output  1  one-cycle pulse when a sweep is cancelled.
pass  output  1  high when the last completed sweep had err_count == 0.
err_count  output  3  number of mismatching vectors, 0..4.
fail_mask  output  4  bit i set if vector i mismatched.
vector_idx  output  2  current vector index.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, gate_in0=0, gate_in1=0, busy=0, done=0, aborted=0, pass=0, err_count=0, fail_mask=0, vector_idx=0, settle counter=0.
- States: IDLE, RUN, FINISH.
- IDLE to RUN, on an edge with start=1:
  - vector_idx=0 and gate_in={0,0}.
  - settle counter loaded with SETTLE_CYCLES-1.
  - busy=1, and err_count, fail_mask and pass cleared.
- RUN, settle counter != 0: decrement the counter; the vector is held.
- RUN, settle counter == 0 (sample edge):
  - Compare gate_out against EXP_TABLE[vector_idx].
  - On mismatch, set fail_mask[vector_idx] and increment err_count.
  - If vector_idx < 3: increment vector_idx, apply the new vector on the same edge, and reload the counter.
  - If vector_idx == 3: go to FINISH.
- Timing: each vector is held exactly SETTLE_CYCLES cycles. Sample edges fall at E0+k*SETTLE_CYCLES for k=1..4, where E0 is the edge that accepted start.
- FINISH (one cycle):
  - done=1; pass=(final err_count==0), counting the mismatch from the last sample.
  - busy=0 and gate_in returns to 00.
  - Next state is IDLE.
  - Net effect: done is high in the cycle after edge E0+4*SETTLE_CYCLES.
- In IDLE the last err_count, fail_mask and pass are held until the next start.
- start while busy or in FINISH: ignored; it does not restart or queue.
- abort while busy:
  - The next edge goes to IDLE, asserts aborted=1 for one cycle, and returns gate_in to 00.
  - No done pulse; pass=0; fail_mask and err_count keep their partial values.
  - abort has priority over a simultaneous sample on the same edge: that sample is discarded.
- abort and start together in IDLE: start wins and abort is ignored.
- rst mid-sweep: immediate return to reset values on that edge; no done or aborted pulse.
- err_count never exceeds 4; there is no wrap.

Test Plan:
1. Default parameters, XorGate connected, start pulse at edge E0 -> gate_in sequence 00,01,10,11, each held 2 cycles; done pulse in the cycle after E0+8; pass=1, err_count=0, fail_mask=4'b0000.
2. AND function wired as gate_out (EXP_TABLE=0110) -> fail_mask=4'b1110, err_count=3, pass=0, done pulses once.
3. gate_out tied to 1, SETTLE_CYCLES=1 -> fail_mask=4'b1001, err_count=2, pass=0; done in the cycle after E0+4.
4. start re-pulsed at E0+3, then abort asserted at E0+5 -> the extra start has no effect; aborted pulse in the cycle after E0+5; busy=0; gate_in=00; no done; pass=0.
5. rst asserted at E0+4 mid-sweep -> next cycle all outputs at reset values; a following start runs a full clean sweep with pass=1.
6. EXP_TABLE=4'b1000 with an AND gate connected -> pass=1, err_count=0.

Source files
------------

// File: rtl/gate_sweep_controller.sv
// Exhaustive sweep of a 2-input gate: drives vectors 00..11, samples the gate
// after a programmable settle time and compares against a truth table.
module gate_sweep_controller #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXP_TABLE     = 4'b0110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_out,
  output logic       gate_in0,
  output logic       gate_in1,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask,
  output logic [1:0] vector_idx
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       vec_q, vec_d;
  logic             in0_q, in0_d;
  logic             in1_q, in1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             pass_q, pass_d;
  logic [2:0]       err_q, err_d;
  logic [3:0]       mask_q, mask_d;
  logic             mismatch_c;

  assign mismatch_c = (gate_out != EXP_TABLE[vec_q]);

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    in0_d     = in0_q;
    in1_d     = in1_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    mask_d    = mask_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = 2'd0;
          in0_d   = 1'b0;
          in1_d   = 1'b0;
          cnt_d   = CNT_RELOAD;
          busy_d  = 1'b1;
          err_d   = 3'd0;
          mask_d  = 4'd0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        // Abort wins over a sample on the same edge; that sample is dropped
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          busy_d    = 1'b0;
          in0_d     = 1'b0;
          in1_d     = 1'b0;
          pass_d    = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (mismatch_c) begin
            mask_d[vec_q] = 1'b1;
            err_d         = err_q + 3'd1;
          end
          if (vec_q != 2'd3) begin
            vec_d = vec_q + 2'd1;
            in0_d = vec_d[1];
            in1_d = vec_d[0];
            cnt_d = CNT_RELOAD;
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            in0_d   = 1'b0;
            in1_d   = 1'b0;
            pass_d  = (err_d == 3'd0);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      vec_q     <= 2'd0;
      in0_q     <= 1'b0;
      in1_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 3'd0;
      mask_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vec_q     <= vec_d;
      in0_q     <= in0_d;
      in1_q     <= in1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      mask_q    <= mask_d;
    end
  end

  assign gate_in0   = in0_q;
  assign gate_in1   = in1_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_mask  = mask_q;
  assign vector_idx = vec_q;

endmodule
